// File: rtl/mix_columns_seq.sv
// Sequential AES forward MixColumns: one 32-bit column per clock through a single
// GF(2^8) mixer, full 128-bit result published with a one-cycle Done pulse.
module mix_columns_seq (
  input  logic         CLK,
  input  logic         RST,
  input  logic         Start,
  input  logic [127:0] State_In,
  output logic         Busy,
  output logic         Done,
  output logic [127:0] State_Out
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t       state_q, state_d;
  logic [1:0]   col_q, col_d;
  logic         accept;
  logic         last;

  logic [127:0] latch_p0;
  // Columns 0-2 only; column 3 goes from the mixer straight into State_Out.
  logic [95:0]  acc_p1;
  logic [127:0] out_q;
  logic         done_q;

  logic [31:0]  col_in;
  logic [31:0]  col_mix;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] d0, d1, d2, d3;
    logic [7:0] o0, o1, o2, o3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    d0 = xtime(a0);
    d1 = xtime(a1);
    d2 = xtime(a2);
    d3 = xtime(a3);
    o0 = d0 ^ (d1 ^ a1) ^ a2 ^ a3;
    o1 = a0 ^ d1 ^ (d2 ^ a2) ^ a3;
    o2 = a0 ^ a1 ^ d2 ^ (d3 ^ a3);
    o3 = (d0 ^ a0) ^ a1 ^ a2 ^ d3;
    return {o0, o1, o2, o3};
  endfunction

  // Stage p0 -> mixer: counter selects one column of the latched state
  always_comb begin
    col_in = latch_p0[127:96];
    case (col_q)
      2'd0: col_in = latch_p0[127:96];
      2'd1: col_in = latch_p0[95:64];
      2'd2: col_in = latch_p0[63:32];
      2'd3: col_in = latch_p0[31:0];
      default: col_in = latch_p0[127:96];
    endcase
  end

  assign col_mix = mix_col(col_in);

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    accept  = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start) begin
          accept  = 1'b1;
          state_d = RUN;
          col_d   = 2'd0;
        end
      end
      RUN: begin
        col_d = col_q + 2'd1;
        if (col_q == 2'd3) begin
          last    = 1'b1;
          state_d = IDLE;
          col_d   = 2'd0;
        end
      end
      default: begin
        state_d = IDLE;
        col_d   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      col_q   <= 2'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      done_q  <= last;
    end
  end

  // Stage p1: accumulate mixed columns; publish the whole state at once
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      latch_p0 <= 128'h0;
      acc_p1   <= 96'h0;
      out_q    <= 128'h0;
    end else begin
      if (accept) begin
        latch_p0 <= State_In;
      end
      if (state_q == RUN) begin
        case (col_q)
          2'd0: acc_p1[95:64] <= col_mix;
          2'd1: acc_p1[63:32] <= col_mix;
          2'd2: acc_p1[31:0]  <= col_mix;
          default: ;
        endcase
      end
      if (last) begin
        out_q <= {acc_p1, col_mix};
      end
    end
  end

  assign Busy      = (state_q == RUN);
  assign Done      = done_q;
  assign State_Out = out_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Directed and random checks for the sequential MixColumns engine.
module tb_mix_columns_seq;

  logic         CLK = 1'b0;
  logic         RST;
  logic         Start;
  logic [127:0] State_In;
  logic         Busy;
  logic         Done;
  logic [127:0] State_Out;

  int tests = 0;
  int fails = 0;

  localparam logic [127:0] FIPS_IN  = 128'hdb135345_f20a225c_01010101_2d26314c;
  localparam logic [127:0] FIPS_OUT = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
  localparam logic [127:0] APPB_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] APPB_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;
  localparam logic [127:0] C6_IN    = 128'hc6c6c6c6_d4d4d4d5_01010101_db135345;
  localparam logic [127:0] C6_OUT   = 128'hc6c6c6c6_d5d5d7d6_01010101_8e4da1bc;

  mix_columns_seq dut (
    .CLK       (CLK),
    .RST       (RST),
    .Start     (Start),
    .State_In  (State_In),
    .Busy      (Busy),
    .Done      (Done),
    .State_Out (State_Out)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Circulant matrix multiply per column; inv selects the InvMixColumns row.
  function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic inv);
    logic [7:0]   row0 [4];
    logic [127:0] r;
    logic [7:0]   acc;
    if (inv) begin
      row0[0] = 8'h0e; row0[1] = 8'h0b; row0[2] = 8'h0d; row0[3] = 8'h09;
    end else begin
      row0[0] = 8'h02; row0[1] = 8'h03; row0[2] = 8'h01; row0[3] = 8'h01;
    end
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int rr = 0; rr < 4; rr++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gmul(row0[(k - rr) & 3], s[127 - 8*(4*c + k) -: 8]);
        r[127 - 8*(4*c + rr) -: 8] = acc;
      end
    end
    return r;
  endfunction

  task automatic test_reset();
    RST = 1'b1;
    Start = 1'b0;
    State_In = '0;
    repeat (2) @(posedge CLK);
    #1;
    tests++;
    if (Busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", Busy); end
    tests++;
    if (Done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", Done); end
    tests++;
    if (State_Out !== 128'h0) begin fails++; $display("FAIL reset_out: got %h want 0", State_Out); end
    RST = 1'b0;
    @(posedge CLK);
    #1;
    tests++;
    if (Busy !== 1'b0 || Done !== 1'b0) begin
      fails++; $display("FAIL idle_after_reset: busy %b done %b want 0 0", Busy, Done);
    end
  endtask

  task automatic test_fips_columns();
    int busy_cnt = 0;
    int done_cnt = 0;
    int done_at  = -1;
    logic [127:0] res = 'x;
    State_In = FIPS_IN;
    Start = 1'b1;
    @(posedge CLK);
    #1;
    Start = 1'b0;
    State_In = {4{32'hffffffff}};
    if (Busy) busy_cnt++;
    for (int k = 1; k <= 10; k++) begin
      @(posedge CLK);
      #1;
      if (Busy) busy_cnt++;
      if (Done) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
        res = State_Out;
      end
    end
    tests++;
    if (done_at !== 4) begin fails++; $display("FAIL fips_latency: got %0d want 4", done_at); end
    tests++;
    if (done_cnt !== 1) begin fails++; $display("FAIL fips_done_count: got %0d want 1", done_cnt); end
    tests++;
    if (busy_cnt !== 4) begin fails++; $display("FAIL fips_busy_cycles: got %0d want 4", busy_cnt); end
    tests++;
    if (res !== FIPS_OUT) begin fails++; $display("FAIL fips_result: got %h want %h", res, FIPS_OUT); end
    tests++;
    if (State_Out !== FIPS_OUT) begin fails++; $display("FAIL fips_hold: got %h want %h", State_Out, FIPS_OUT); end
  endtask

  task automatic test_appendix_b();
    logic got = 1'b0;
    State_In = APPB_IN;
    Start = 1'b1;
    @(posedge CLK);
    #1;
    Start = 1'b0;
    for (int k = 1; k <= 8 && !got; k++) begin
      @(posedge CLK);
      #1;
      if (Done) got = 1'b1;
    end
    tests++;
    if (!got) begin
      fails++; $display("FAIL appb_done: got no Done want pulse");
    end else if (State_Out !== APPB_OUT) begin
      fails++; $display("FAIL appb_result: got %h want %h", State_Out, APPB_OUT);
    end
  endtask

  task automatic test_back_to_back();
    int done_t [$];
    logic [127:0] done_v [$];
    for (int t = 0; t <= 20; t++) begin
      Start = (t <= 10);
      if (t == 0)       State_In = FIPS_IN;
      else if (t == 5)  State_In = APPB_IN;
      else if (t == 10) State_In = C6_IN;
      else              State_In = {$urandom, $urandom, $urandom, $urandom};
      @(posedge CLK);
      #1;
      if (Done) begin
        done_t.push_back(t);
        done_v.push_back(State_Out);
      end
    end
    Start = 1'b0;
    tests++;
    if (done_t.size() != 3) begin
      fails++; $display("FAIL b2b_done_count: got %0d want 3", done_t.size());
    end else begin
      tests++;
      if (done_t[0] != 4 || done_t[1] != 9 || done_t[2] != 14) begin
        fails++; $display("FAIL b2b_timing: got %0d %0d %0d want 4 9 14", done_t[0], done_t[1], done_t[2]);
      end
      tests++;
      if (done_v[0] !== FIPS_OUT) begin fails++; $display("FAIL b2b_res0: got %h want %h", done_v[0], FIPS_OUT); end
      tests++;
      if (done_v[1] !== APPB_OUT) begin fails++; $display("FAIL b2b_res1: got %h want %h", done_v[1], APPB_OUT); end
      tests++;
      if (done_v[2] !== C6_OUT) begin fails++; $display("FAIL b2b_res2: got %h want %h", done_v[2], C6_OUT); end
    end
  endtask

  task automatic test_reset_abort();
    int done_cnt = 0;
    int done_at  = -1;
    State_In = APPB_IN;
    Start = 1'b1;
    @(posedge CLK);
    #1;
    Start = 1'b0;
    @(posedge CLK);
    #2;
    RST = 1'b1;
    #1;
    tests++;
    if (Busy !== 1'b0 || Done !== 1'b0) begin
      fails++; $display("FAIL abort_async_ctrl: busy %b done %b want 0 0", Busy, Done);
    end
    tests++;
    if (State_Out !== 128'h0) begin fails++; $display("FAIL abort_async_out: got %h want 0", State_Out); end
    @(posedge CLK);
    #1;
    if (Done) done_cnt++;
    @(negedge CLK);
    RST = 1'b0;
    State_In = C6_IN;
    Start = 1'b1;
    @(posedge CLK);
    #1;
    Start = 1'b0;
    tests++;
    if (Busy !== 1'b1) begin fails++; $display("FAIL abort_restart_busy: got %b want 1", Busy); end
    tests++;
    if (State_Out !== 128'h0) begin fails++; $display("FAIL abort_out_zero: got %h want 0", State_Out); end
    for (int k = 1; k <= 8; k++) begin
      @(posedge CLK);
      #1;
      if (Done) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
    end
    tests++;
    if (done_cnt !== 1 || done_at !== 4) begin
      fails++; $display("FAIL abort_done: got count %0d at %0d want 1 at 4", done_cnt, done_at);
    end
    tests++;
    if (State_Out !== C6_OUT) begin fails++; $display("FAIL abort_result: got %h want %h", State_Out, C6_OUT); end
  endtask

  task automatic test_random();
    logic [127:0] s;
    logic [127:0] exp;
    logic got;
    for (int n = 0; n < 1000; n++) begin
      s = {$urandom, $urandom, $urandom, $urandom};
      exp = ref_mix(s, 1'b0);
      State_In = s;
      Start = 1'b1;
      @(posedge CLK);
      #1;
      Start = 1'b0;
      got = 1'b0;
      for (int k = 1; k <= 8 && !got; k++) begin
        @(posedge CLK);
        #1;
        if (Done) got = 1'b1;
      end
      tests++;
      if (!got) begin
        fails++; $display("FAIL rand_timeout[%0d]: got no Done want pulse", n);
      end else if (State_Out !== exp) begin
        fails++; $display("FAIL rand_result[%0d]: got %h want %h", n, State_Out, exp);
      end
      tests++;
      if (ref_mix(State_Out, 1'b1) !== s) begin
        fails++; $display("FAIL rand_roundtrip[%0d]: got %h want %h", n, ref_mix(State_Out, 1'b1), s);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fips_columns();
    test_appendix_b();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
